// File: rtl/frame_arbiter_if.sv
// Handshake bundle around the frame arbiter: two FWFT source FIFOs on one side,
// the pipeline input FIFO on the other, plus frame status.
interface frame_arbiter_if #(
    parameter int DWIDTH = 24
);
    logic [DWIDTH-1:0] in0_dout;
    logic              in0_empty;
    logic              in0_rd_en;
    logic [DWIDTH-1:0] in1_dout;
    logic              in1_empty;
    logic              in1_rd_en;
    logic [DWIDTH-1:0] out_din;
    logic              out_full;
    logic              out_wr_en;
    logic              grant_id;
    logic              busy;
    logic              frame_start;
    logic              frame_done;

    // master is the FIFO/pipeline environment, slave is the arbiter itself
    modport master (
        output in0_dout, in0_empty, in1_dout, in1_empty, out_full,
        input  in0_rd_en, in1_rd_en, out_din, out_wr_en,
        input  grant_id, busy, frame_start, frame_done
    );

    modport slave (
        input  in0_dout, in0_empty, in1_dout, in1_empty, out_full,
        output in0_rd_en, in1_rd_en, out_din, out_wr_en,
        output grant_id, busy, frame_start, frame_done
    );
endinterface

// File: rtl/frame_arbiter.sv
// Round-robin whole-frame arbiter: two FWFT RGB sources share one pipeline input
// FIFO, with zero-latency pass-through and a fixed idle gap after every frame.
module frame_arbiter #(
    parameter int DWIDTH     = 24,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic           clock,
    input  logic           reset,
    frame_arbiter_if.slave bus
);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     col, col_nxt;
    logic [RW-1:0]     row, row_nxt;
    logic [GW-1:0]     gap_cnt, gap_nxt;
    logic              grant_q, grant_nxt;
    logic              last_grant, last_nxt;
    logic              done_q, done_nxt;
    logic              sel_empty;
    logic [DWIDTH-1:0] sel_dout;
    logic              xfer;
    logic              req0, req1;

    always_comb begin
        req0      = !bus.in0_empty;
        req1      = !bus.in1_empty;
        sel_empty = grant_q ? bus.in1_empty : bus.in0_empty;
        sel_dout  = grant_q ? bus.in1_dout  : bus.in0_dout;
        xfer      = (state == RUN) && !sel_empty && !bus.out_full;
    end

    assign bus.in0_rd_en   = xfer && !grant_q;
    assign bus.in1_rd_en   = xfer &&  grant_q;
    assign bus.out_wr_en   = xfer;
    assign bus.out_din     = xfer ? sel_dout : '0;
    assign bus.frame_start = xfer && (col == '0) && (row == '0);
    assign bus.busy        = (state != IDLE);
    assign bus.grant_id    = grant_q;
    assign bus.frame_done  = done_q;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        gap_nxt   = gap_cnt;
        grant_nxt = grant_q;
        last_nxt  = last_grant;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = RUN;
                    grant_nxt = (req0 && req1) ? !last_grant : req1;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (col == COL_LAST) begin
                        col_nxt = '0;
                        if (row == ROW_LAST) begin
                            row_nxt   = '0;
                            last_nxt  = grant_q;
                            done_nxt  = 1'b1;
                            state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                        end else begin
                            row_nxt = row + 1'b1;
                        end
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant resets to 1 so source 0 wins the first contested grant
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            gap_cnt    <= '0;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state      <= state_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            gap_cnt    <= gap_nxt;
            grant_q    <= grant_nxt;
            last_grant <= last_nxt;
            done_q     <= done_nxt;
        end
    end
endmodule

// File: tb/tb_frame_arbiter.sv
// Self-checking bench for frame_arbiter: an arbitration vector table, then
// scoreboarded frame sequences for ordering, stalls, starvation, reset and gap.
module tb_frame_arbiter;
    localparam int DW   = 24;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    typedef struct {
        logic [DW-1:0] data;
        logic          src;
        logic          first;
        logic          last;
    } exp_t;

    typedef struct {
        logic          e0, e1, full;
        logic          exp_busy, exp_gid, exp_rd0, exp_rd1, exp_wr;
        logic [DW-1:0] exp_din;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    frame_arbiter_if #(.DWIDTH(DW)) bus ();
    frame_arbiter_if #(.DWIDTH(DW)) bus_z ();

    frame_arbiter #(.DWIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .GAP_CYCLES(2)) dut (
        .clock(clk), .reset(rst_n), .bus(bus)
    );
    frame_arbiter #(.DWIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .GAP_CYCLES(0)) dut_z (
        .clock(clk), .reset(rst_n), .bus(bus_z)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] src0[$];
    logic [DW-1:0] src1[$];
    exp_t          exp_q[$];
    int            wr_cyc[$];
    vec_t          vecs[6];
    bit            use_z = 1'b0;
    bit            exp_done;
    int            cyc = 0;
    int            wr_cnt, full_at, full_len, full_left, hold0_at, hold0_len, hold0_left;
    logic          s_rd0, s_rd1, s_wr, s_start, s_done, s_busy, s_gid;
    logic [DW-1:0] s_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        logic          e0, e1, f;
        logic [DW-1:0] d0, d1;
        e0 = (src0.size() == 0) || (hold0_left > 0);
        e1 = (src1.size() == 0);
        f  = (full_left > 0);
        d0 = (src0.size() > 0) ? src0[0] : '0;
        d1 = (src1.size() > 0) ? src1[0] : '0;
        if (!use_z) begin
            bus.in0_dout = d0; bus.in0_empty = e0; bus.in1_dout = d1; bus.in1_empty = e1; bus.out_full = f;
            bus_z.in0_dout = '0; bus_z.in0_empty = 1'b1; bus_z.in1_dout = '0; bus_z.in1_empty = 1'b1;
            bus_z.out_full = 1'b0;
        end else begin
            bus_z.in0_dout = d0; bus_z.in0_empty = e0; bus_z.in1_dout = d1; bus_z.in1_empty = e1;
            bus_z.out_full = f;
            bus.in0_dout = '0; bus.in0_empty = 1'b1; bus.in1_dout = '0; bus.in1_empty = 1'b1; bus.out_full = 1'b0;
        end
    endtask

    task automatic sample();
        if (!use_z) begin
            s_rd0 = bus.in0_rd_en; s_rd1 = bus.in1_rd_en; s_wr = bus.out_wr_en; s_din = bus.out_din;
            s_start = bus.frame_start; s_done = bus.frame_done; s_busy = bus.busy; s_gid = bus.grant_id;
        end else begin
            s_rd0 = bus_z.in0_rd_en; s_rd1 = bus_z.in1_rd_en; s_wr = bus_z.out_wr_en; s_din = bus_z.out_din;
            s_start = bus_z.frame_start; s_done = bus_z.frame_done; s_busy = bus_z.busy;
            s_gid = bus_z.grant_id;
        end
    endtask

    // One clock: drive FIFO heads, compare against the scoreboard, then pop what the DUT read.
    task automatic cycle();
        exp_t e;
        drive();
        #1;
        sample();
        check("frame_done", s_done, exp_done);
        exp_done = 1'b0;
        if (full_left > 0)  check("wr_while_full", s_wr, 0);
        if (hold0_left > 0) check("rd0_while_empty", s_rd0, 0);
        if (s_wr) begin
            wr_cyc.push_back(cyc);
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", s_wr, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_din", s_din, e.data);
                check("grant_id", s_gid, e.src);
                check("rd_granted", e.src ? s_rd1 : s_rd0, 1);
                check("rd_other", e.src ? s_rd0 : s_rd1, 0);
                check("frame_start", s_start, e.first);
                exp_done = e.last;
            end
        end else begin
            check("rd_without_wr", {s_rd0, s_rd1}, 0);
            check("start_without_wr", s_start, 0);
            check("din_without_wr", s_din, 0);
        end
        if (s_rd0 && src0.size() > 0) void'(src0.pop_front());
        if (s_rd1 && src1.size() > 0) void'(src1.pop_front());
        if (full_left > 0)  full_left--;
        if (hold0_left > 0) hold0_left--;
        if (s_wr && wr_cnt == full_at)  full_left  = full_len;
        if (s_wr && wr_cnt == hold0_at) hold0_left = hold0_len;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src0.delete(); src1.delete(); exp_q.delete(); wr_cyc.delete();
        exp_done = 1'b0; wr_cnt = 0;
        full_at = -1; full_len = 0; full_left = 0;
        hold0_at = -1; hold0_len = 0; hold0_left = 0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input bit src, input logic [DW-1:0] base, input int n);
        for (int i = 1; i <= n; i++) begin
            if (src) src1.push_back(base + DW'(i));
            else     src0.push_back(base + DW'(i));
        end
    endtask

    task automatic expect_frame(input bit src, input logic [DW-1:0] base, input int first_idx);
        for (int i = 0; i < NPIX; i++) begin
            exp_t e;
            e.data  = base + DW'(first_idx + i);
            e.src   = src;
            e.first = (i == 0);
            e.last  = (i == NPIX - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && exp_q.size() > 0; n++) cycle();
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic span_check(input string name, input int i, input int j, input int exp);
        if (wr_cyc.size() > j) check(name, wr_cyc[j] - wr_cyc[i], exp);
        else                   check({name, "_missing"}, wr_cyc.size(), j + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {e0, e1, full, busy, grant_id, rd0, rd1, wr, din} in the first RUN cycle
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h111111};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h222222};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h111111};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            bus.in0_dout = 24'h111111; bus.in1_dout = 24'h222222;
            bus.in0_empty = vecs[i].e0; bus.in1_empty = vecs[i].e1; bus.out_full = vecs[i].full;
            #1;
            sample();
            check("idle_busy", s_busy, 0);
            check("idle_grant", s_gid, 0);
            check("idle_no_move", {s_rd0, s_rd1, s_wr}, 0);
            check("idle_done", s_done, 0);
            @(posedge clk);
            @(negedge clk);
            #1;
            sample();
            check("vec_busy", s_busy, vecs[i].exp_busy);
            check("vec_grant", s_gid, vecs[i].exp_gid);
            check("vec_rd0", s_rd0, vecs[i].exp_rd0);
            check("vec_rd1", s_rd1, vecs[i].exp_rd1);
            check("vec_wr", s_wr, vecs[i].exp_wr);
            check("vec_din", s_din, vecs[i].exp_din);
            check("vec_start", s_start, vecs[i].exp_wr);
            @(negedge clk);
        end

        // Single source frame, then the two-cycle gap
        do_reset();
        load(0, 24'h000000, 8);
        expect_frame(0, 24'h000000, 1);
        drain(40);
        span_check("s1_consecutive", 0, 7, 7);
        cycle(); check("s1_busy_gap1", s_busy, 1);
        cycle(); check("s1_busy_gap2", s_busy, 1);
        cycle(); check("s1_busy_idle", s_busy, 0);

        // Both sources loaded: frames alternate 0,1,0,1
        do_reset();
        load(0, 24'hA00000, 16);
        load(1, 24'hB00000, 16);
        expect_frame(0, 24'hA00000, 1);
        expect_frame(1, 24'hB00000, 1);
        expect_frame(0, 24'hA00000, 9);
        expect_frame(1, 24'hB00000, 9);
        drain(200);

        // Pipeline full for 5 cycles after pixel 3
        do_reset();
        load(0, 24'h300000, 8);
        full_at = 3; full_len = 5;
        expect_frame(0, 24'h300000, 1);
        drain(60);
        span_check("s3_stall_span", 0, 7, 12);

        // Source 0 runs dry after pixel 5 for 10 cycles; source 1 must starve
        do_reset();
        load(0, 24'h400000, 8);
        load(1, 24'h410000, 8);
        hold0_at = 5; hold0_len = 10;
        expect_frame(0, 24'h400000, 1);
        drain(80);
        span_check("s4_hold_span", 0, 7, 17);
        check("s4_src1_untouched", src1.size(), 8);

        // Reset in the middle of a source 1 frame
        do_reset();
        load(1, 24'hD00000, 8);
        expect_frame(1, 24'hD00000, 1);
        for (int n = 0; n < 50 && wr_cnt < 3; n++) cycle();
        check("s5_partial_px", wr_cnt, 3);
        drive();
        #1;
        sample();
        check("s5_inflight_wr", s_wr, 1);
        rst_n = 1'b0;
        #1;
        sample();
        check("s5_rst_rd", {s_rd0, s_rd1, s_wr}, 0);
        check("s5_rst_din", s_din, 0);
        check("s5_rst_status", {s_busy, s_start, s_done, s_gid}, 0);
        do_reset();
        load(0, 24'hE00000, 8);
        load(1, 24'hF00000, 8);
        expect_frame(0, 24'hE00000, 1);
        cycle();
        cycle();
        check("s5_grant_after_reset", s_gid, 0);
        check("s5_first_after_reset", s_din, 24'hE00001);

        // Zero-gap instance: back-to-back frames separated by one IDLE cycle
        use_z = 1'b1;
        do_reset();
        load(0, 24'h500000, 16);
        expect_frame(0, 24'h500000, 1);
        expect_frame(0, 24'h500000, 9);
        drain(80);
        span_check("s6_refill_gap", 7, 8, 2);
        use_z = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
